// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: op encodings, mul/div FSM states and iteration count.
package mips_pkg;

  localparam int unsigned ITER = 32;
  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StFix  = 2'b11
  } state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-facing bus of the multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, A, B, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Multiply: {hi,lo} is the partial product with the multiplier in lo.
// Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] m_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Select the multiply or divide iteration.
  always_comb begin
    sum    = {1'b0, hi_i} + {1'b0, (lo_i[0] ? m_i : 32'd0)};
    rem_sh = {hi_i, lo_i[31]};
    diff   = rem_sh - {1'b0, m_i};
    hi_o   = hi_i;
    lo_o   = lo_i;
    if (is_div_i) begin
      if (!diff[32]) begin
        hi_o = diff[31:0];
        lo_o = {lo_i[30:0], 1'b1};
      end else begin
        hi_o = rem_sh[31:0];
        lo_o = {lo_i[30:0], 1'b0};
      end
    end else begin
      {hi_o, lo_o} = {sum, lo_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: control FSM, counter, sign fix, HI/LO.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  muldiv_unit_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       whi_q, whi_d, wlo_q, wlo_d, m_q, m_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic [31:0]       step_hi, step_lo;
  logic              signed_op;
  logic [63:0]       prod_fix;
  logic [31:0]       fix_hi, fix_lo;

  muldiv_step u_step (
    .is_div_i (op_q[1]),
    .hi_i     (whi_q),
    .lo_i     (wlo_q),
    .m_i      (m_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign correction and HI/LO placement of the finished result.
  always_comb begin
    signed_op = (op_q == OpMult) || (op_q == OpDiv);
    prod_fix  = {whi_q, wlo_q};
    if (signed_op && (a_q[31] ^ b_q[31])) begin
      prod_fix = ~{whi_q, wlo_q} + 64'd1;
    end
    fix_hi = prod_fix[63:32];
    fix_lo = prod_fix[31:0];
    if (op_q[1]) begin
      if (b_q == 32'd0) begin
        fix_hi = a_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = (signed_op && (a_q[31] ^ b_q[31])) ? (~wlo_q + 32'd1) : wlo_q;
        fix_hi = (signed_op && a_q[31]) ? (~whi_q + 32'd1) : whi_q;
      end
    end
  end

  // Next-state logic for the FSM, datapath and architectural HI/LO.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = op_e'(bus.op);
          a_d   = bus.A;
          b_d   = bus.B;
          whi_d = 32'd0;
          wlo_d = magnitude(bus.A, ~bus.op[0]);
          m_d   = magnitude(bus.B, ~bus.op[0]);
          cnt_d = '0;
          if (!bus.op[1]) begin
            state_d = StMul;
          end else if (bus.B == 32'd0) begin
            state_d = StFix;
          end else begin
            state_d = StDiv;
          end
        end else begin
          if (bus.mthi) hi_d = bus.A;
          if (bus.mtlo) lo_d = bus.A;
        end
      end
      StMul, StDiv: begin
        whi_d = step_hi;
        wlo_d = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) state_d = StFix;
      end
      StFix: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation without touching HI/LO beyond clearing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      op_q    <= OpMult;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, decoupled done monitor.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned due;
    string       tag;
  } exp_t;

  exp_t sb[$];

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done at cycle %0d want no result pending", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.tag, ".hi"}, bus.hi, e.hi);
          chk({e.tag, ".lo"}, bus.lo, e.lo);
          chk({e.tag, ".done_cycle"}, cyc, e.due);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input string tag);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    sb.push_back('{eh, el, cyc + 1 + lat, tag});
    @(negedge CLK);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int bc);
    int n = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got no done in %0d cycles want done", tag, n);
    end
    chk({tag, ".busy_at_done"}, bus.busy, 1'b0);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int lat,
                     input string tag);
    int bc;
    issue(op, a, b, eh, el, lat, tag);
    wait_done(tag, bc);
    chk({tag, ".busy_cycles"}, bc, lat);
  endtask

  initial begin
    int bc;
    RST      = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst.hi", bus.hi, 32'h0);
    chk("rst.lo", bus.lo, 32'h0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // Register moves from A.
    bus.mthi = 1'b1; bus.A = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus.mthi = 1'b0;
    chk("mthi.hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi.lo", bus.lo, 32'h0);
    bus.mtlo = 1'b1; bus.A = 32'h0BAD_F00D;
    @(negedge CLK);
    bus.mtlo = 1'b0;
    chk("mtlo.lo", bus.lo, 32'h0BAD_F00D);
    chk("mtlo.hi", bus.hi, 32'hDEAD_BEEF);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.A = 32'h5A5A_5A5A;
    @(negedge CLK);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("mtboth.hi", bus.hi, 32'h5A5A_5A5A);
    chk("mtboth.lo", bus.lo, 32'h5A5A_5A5A);

    // Arithmetic vectors; consecutive runs also exercise start on the done cycle.
    run(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mult_m1x2");
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max");
    run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7d2");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_ovf");
    run(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1, "divu_by0");
    run(2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1, "div_by0");
    run(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult_7xm3");
    run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div_7dm2");
    run(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, "divu_big");
    run(2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 33, "multu_carry");

    // start together with mthi: the move must be dropped.
    bus.mthi = 1'b1;
    issue(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F, 33, "start_vs_mthi");
    chk("start_vs_mthi.hi_kept", bus.hi, 32'h0000_0001);
    wait_done("start_vs_mthi", bc);

    // Second start and moves while busy must be ignored.
    issue(2'b01, 32'h0001_2345, 32'h0000_1000, 32'h0, 32'h1234_5000, 33, "busy_ignore");
    repeat (4) @(negedge CLK);
    bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'h5; bus.B = 32'h0;
    bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("busy_ignore.hi_kept", bus.hi, 32'h0);
    chk("busy_ignore.lo_kept", bus.lo, 32'h0000_000F);
    chk("busy_ignore.busy", bus.busy, 1'b1);
    wait_done("busy_ignore", bc);

    // Reset mid-multiply aborts with no result.
    bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'hFFFF_FFFF; bus.B = 32'h2;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (9) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort.busy", bus.busy, 1'b0);
    chk("abort.hi", bus.hi, 32'h0);
    chk("abort.lo", bus.lo, 32'h0);
    chk("abort.done", bus.done, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run(2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0000_000C, 33, "multu_3x4");

    repeat (40) @(negedge CLK);
    chk("pending_results", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
